prog_ctr: RTL
=============

Name: prog_ctr

Overview:
- Program-counter and branch-resolution stage for the 8-bit datapath.
- Sits directly downstream of the ALU: it registers the ALU Zero output into a condition flag, then uses that flag to choose the next instruction address.
- Also provides the start/halt handshake to the test harness, and a 16-entry branch target lookup.

Parameters:
PC_W, 10, program-counter width in bits; all next-PC arithmetic is modulo 2^PC_W.
LUT_IDX_W, 4, width of the branch-target lookup index (16 entries).

Ports:
Clk  input  1  system clock, rising-edge.
Reset  input  1  asynchronous, active-high reset.
Start  input  1  harness request to begin execution at StartAddr.
StartAddr  input  PC_W  address loaded on an accepted Start.
Halt  input  1  decoded halt instruction.
Jump  input  1  unconditional jump; LUT entry is used as an absolute target.
Branch  input  1  conditional branch; LUT entry is used as a signed PC-relative offset.
BrCond  input  1  0 = take branch if ZeroFlag=1; 1 = take branch if ZeroFlag=0.
TargetIdx  input  LUT_IDX_W  lookup-table index.
ZeroIn  input  1  Zero output of the ALU.
FlagWe  input  1  latch ZeroIn into ZeroFlag.
ProgCtr  output  PC_W  current instruction address (registered).
ZeroFlag  output  1  registered condition flag.
Running  output  1  high while in state RUN.
Done  output  1  high while in state HALTED.

Behaviour:
- States: IDLE, RUN, HALTED. Encoding is one-hot or binary; it is not visible at the ports.
- Reset (async, any time, including mid-run):
  - state goes to IDLE.
  - ProgCtr=0, ZeroFlag=0, Running=0, Done=0.
  - Reset dominates every other input.
- IDLE:
  - ProgCtr holds.
  - Start=1 → next edge: ProgCtr=StartAddr, state RUN.
  - All other control inputs are ignored.
- RUN: one next-PC decision per clock. Priority order:
  - Halt → state HALTED; ProgCtr holds the halt address.
  - Jump → ProgCtr = LUT[TargetIdx].
  - Branch with the condition met → ProgCtr = ProgCtr + LUT[TargetIdx].
    - The LUT value is treated as a PC_W-bit two's-complement offset.
    - The result wraps modulo 2^PC_W; no overflow flag.
  - Otherwise (including Branch with the condition not met) → ProgCtr = ProgCtr + 1, wrapping from 2^PC_W-1 to 0.
  - Start is ignored while in RUN.
- Condition evaluation:
  - Uses the registered ZeroFlag, i.e. the value before the current edge.
  - If FlagWe and Branch are both asserted in the same cycle, the branch sees the old flag and the flag updates at that same edge.
- ZeroFlag:
  - Loads ZeroIn on an edge where FlagWe=1 and state=RUN.
  - Otherwise it holds. It also holds through HALTED and IDLE.
- HALTED:
  - Done=1, ProgCtr holds.
  - Start=1 → ProgCtr=StartAddr, state RUN, Done drops at that edge.
  - ZeroFlag is not cleared by restart.
- Outputs:
  - Running and Done are decoded from the registered state and are glitch-free.
  - Never both high.
- Latency:
  - Every PC update takes effect at the edge following the cycle in which the controls are sampled.
  - The new ProgCtr is valid one cycle later.

Decomposition:
- Shared package holds:
  - state enum values (ST_IDLE, ST_RUN, ST_HALTED).
  - PC_W and LUT_IDX_W defaults.
  - LUT constants, PC_W-bit values: LUT_0=10'h000, LUT_1=10'h004, LUT_2=10'h3FC (-4), LUT_3=10'h020, entries 4-15 = 10'h000.
- One natural sub-module: branch_lut.
  - Purely combinational, TargetIdx → PC_W-bit value, built from the package constants.
  - prog_ctr instantiates it once.

Test Plan:
1. Reset asserted mid-RUN with ProgCtr=0x055 → ProgCtr=0, Running=0, Done=0, ZeroFlag=0 immediately (asynchronous), before the next Clk edge.
2. Start=1, StartAddr=0x3FE, then 3 idle RUN cycles → ProgCtr sequence 0x3FE, 0x3FF, 0x000, 0x001 (wrap); Running=1.
3. ProgCtr=0x010, FlagWe=1 with ZeroIn=1, next cycle Branch=1, BrCond=0, TargetIdx=2 → ProgCtr=0x00C; repeat with BrCond=1 → ProgCtr=0x011.
4. FlagWe=1, ZeroIn=1, Branch=1, BrCond=0, TargetIdx=1 in the same cycle, with old ZeroFlag=0 and ProgCtr=0x020 → branch not taken: ProgCtr=0x021, ZeroFlag=1 after the edge.
5. Jump=1 and Branch=1 with TargetIdx=3, condition met, at ProgCtr=0x100 → ProgCtr=0x020 (jump wins).
6. Halt=1 together with Jump=1 at ProgCtr=0x042 → HALTED, Done=1, ProgCtr stays 0x042 for 5 cycles. Start=1 with StartAddr=0x000 → RUN, Done=0, ProgCtr=0x000.

Source files
------------

// File: rtl/prog_ctr_pkg.sv
`default_nettype none
// ============================================================================
// Module   : prog_ctr_pkg
// Brief    : Shared state encoding, width defaults and branch-target constants
// Revision : 1.0
// ============================================================================
package prog_ctr_pkg;

    localparam int PC_W_DEF      = 10;
    localparam int LUT_IDX_W_DEF = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    localparam logic [PC_W_DEF-1:0] LUT_0    = 10'h000;
    localparam logic [PC_W_DEF-1:0] LUT_1    = 10'h004;
    localparam logic [PC_W_DEF-1:0] LUT_2    = 10'h3FC;
    localparam logic [PC_W_DEF-1:0] LUT_3    = 10'h020;
    localparam logic [PC_W_DEF-1:0] LUT_REST = 10'h000;

endpackage : prog_ctr_pkg
`default_nettype wire

// File: rtl/prog_ctr_branch_lut.sv
`default_nettype none
// ============================================================================
// Module   : branch_lut
// Brief    : Combinational 16-entry branch target / offset lookup
// Revision : 1.0
// ============================================================================
module branch_lut
    import prog_ctr_pkg::*;
#(
    parameter int PC_W      = PC_W_DEF,
    parameter int LUT_IDX_W = LUT_IDX_W_DEF
) (
    input  logic [LUT_IDX_W-1:0] TargetIdx,
    output logic [PC_W-1:0]      Value
);

    // Entries are sign-extended so offsets stay negative at wider PC widths.
    always_comb begin
        Value = PC_W'($signed(LUT_REST));
        case (TargetIdx)
            LUT_IDX_W'(0): Value = PC_W'($signed(LUT_0));
            LUT_IDX_W'(1): Value = PC_W'($signed(LUT_1));
            LUT_IDX_W'(2): Value = PC_W'($signed(LUT_2));
            LUT_IDX_W'(3): Value = PC_W'($signed(LUT_3));
            default:       Value = PC_W'($signed(LUT_REST));
        endcase
    end

endmodule : branch_lut
`default_nettype wire

// File: rtl/prog_ctr.sv
`default_nettype none
// ============================================================================
// Module   : prog_ctr
// Brief    : Program counter with branch resolution and start/halt handshake
// Revision : 1.0
// ============================================================================
module prog_ctr
    import prog_ctr_pkg::*;
#(
    parameter int PC_W      = PC_W_DEF,
    parameter int LUT_IDX_W = LUT_IDX_W_DEF
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 Start,
    input  logic [PC_W-1:0]      StartAddr,
    input  logic                 Halt,
    input  logic                 Jump,
    input  logic                 Branch,
    input  logic                 BrCond,
    input  logic [LUT_IDX_W-1:0] TargetIdx,
    input  logic                 ZeroIn,
    input  logic                 FlagWe,
    output logic [PC_W-1:0]      ProgCtr,
    output logic                 ZeroFlag,
    output logic                 Running,
    output logic                 Done
);

    state_t            state_q;
    logic [PC_W-1:0]   pc_q;
    logic [PC_W-1:0]   pc_d;
    logic              zf_q;
    logic              running_q;
    logic              done_q;
    logic [PC_W-1:0]   lut_val;
    logic              br_taken;

    branch_lut #(
        .PC_W      (PC_W),
        .LUT_IDX_W (LUT_IDX_W)
    ) u_branch_lut (
        .TargetIdx (TargetIdx),
        .Value     (lut_val)
    );

    // Condition uses the flag as it stood before this edge.
    assign br_taken = Branch && (BrCond ? !zf_q : zf_q);

    always_comb begin
        pc_d = pc_q + PC_W'(1);
        if (Jump) begin
            pc_d = lut_val;
        end else if (br_taken) begin
            pc_d = pc_q + lut_val;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q   <= ST_IDLE;
            pc_q      <= '0;
            zf_q      <= 1'b0;
            running_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_HALTED: begin
                    if (Start) begin
                        state_q   <= ST_RUN;
                        pc_q      <= StartAddr;
                        running_q <= 1'b1;
                        done_q    <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (FlagWe) begin
                        zf_q <= ZeroIn;
                    end
                    if (Halt) begin
                        state_q   <= ST_HALTED;
                        running_q <= 1'b0;
                        done_q    <= 1'b1;
                    end else begin
                        pc_q <= pc_d;
                    end
                end
                default: begin
                    state_q   <= ST_IDLE;
                    running_q <= 1'b0;
                    done_q    <= 1'b0;
                end
            endcase
        end
    end

    assign ProgCtr  = pc_q;
    assign ZeroFlag = zf_q;
    assign Running  = running_q;
    assign Done     = done_q;

endmodule : prog_ctr
`default_nettype wire
